// File: rtl/present_key_sequencer_if.sv
// rtl/present_key_sequencer_if.sv - round-key stream between the key sequencer and the round datapath
interface present_key_sequencer_if;
  logic        rk_valid;
  logic        rk_ready;
  logic [63:0] rk;
  logic [4:0]  rk_idx;

  modport master (output rk_valid, output rk, output rk_idx, input rk_ready);
  modport slave  (input rk_valid, input rk, input rk_idx, output rk_ready);
endinterface

// File: rtl/present_key_sequencer.sv
// rtl/present_key_sequencer.sv - iterative PRESENT-80 round-key sequencer
// One shared key_schedule step advances the 80-bit key register per accepted round key.
module present_key_sequencer #(
  parameter int ROUNDS = 31
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [79:0]                     key_in,
  output logic                            busy,
  output logic                            done,
  present_key_sequencer_if.master         rk_if
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [4:0] LAST_IDX = 5'(ROUNDS);

  state_t      state;
  state_t      state_nxt;
  logic [79:0] key_reg;
  logic [79:0] key_nxt;
  logic [4:0]  cnt;
  logic [4:0]  cnt_nxt;
  logic        handshake;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  // Rotate left by 61, S-box the top nibble, fold the round counter into bits 19:15.
  function automatic logic [79:0] key_schedule(input logic [79:0] k, input logic [4:0] rc);
    logic [79:0] r;
    r          = {k[18:0], k[79:19]};
    r[79:76]   = sbox(r[79:76]);
    r[19:15]   = r[19:15] ^ rc;
    return r;
  endfunction

  assign handshake = (state == RUN) && rk_if.rk_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      key_reg <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      key_reg <= key_nxt;
      cnt     <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    key_nxt   = key_reg;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (start) begin
          key_nxt   = key_in;
          cnt_nxt   = '0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (handshake) begin
          if (cnt == LAST_IDX) begin
            state_nxt = DONE;
          end else begin
            key_nxt = key_schedule(key_reg, cnt + 5'd1);
            cnt_nxt = cnt + 5'd1;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy           = (state == RUN);
  assign done           = (state == DONE);
  assign rk_if.rk_valid = (state == RUN);
  assign rk_if.rk       = key_reg[79:16];
  assign rk_if.rk_idx   = cnt;

endmodule
